// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants and helpers used by the
// FP multiplier result path and its bench.
package fp_pkg;

    localparam int          EXP_W        = 8;
    localparam int          MANT_W       = 23;
    localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
    localparam int          FPMUL_LAT    = 4;

    function automatic logic is_nan(input logic [31:0] word);
        return (word[MANT_W +: EXP_W] == EXP_ALL_ONES) && (word[MANT_W-1:0] != '0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers; the head reads as
// zero while empty and the storage array itself is never reset.
module sync_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [N-1:0] din,
    input  logic         pop,
    output logic [N-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wp_q, wp_d;
    logic [AW:0]  rp_q, rp_d;
    logic [N-1:0] mem [DEPTH];

    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (clr) begin
            wp_d = '0;
            rp_d = '0;
        end else begin
            if (push) wp_d = wp_q + 1'b1;
            if (pop)  rp_d = rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wp_q[AW-1:0]] <= din;
    end

    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    assign dout  = empty ? '0 : mem[rp_q[AW-1:0]];

endmodule

// File: rtl/fp_result_collector.sv
// Aligns the operand-valid strobe with FPmul's FP_Z, buffers valid results
// for a ready/valid reader and keeps a sample count plus sticky flags.
module fp_result_collector
    import fp_pkg::*;
#(
    parameter int N     = 32,
    parameter int LAT   = FPMUL_LAT,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N-1:0]     dut_z,
    input  logic             flush,
    output logic [N-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             nan_seen
);

    logic [LAT-1:0]   vpipe_q, vpipe_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             nan_q, nan_d;
    logic             cap, push, pop, empty, full;

    assign cap       = vpipe_q[LAT-1];
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready && !flush;
    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    assign push      = cap && (!full || pop) && !flush;

    always_comb begin
        vpipe_d = '0;
        count_d = count_q;
        ovf_d   = ovf_q;
        nan_d   = nan_q;
        if (flush) begin
            ovf_d = 1'b0;
            nan_d = 1'b0;
        end else begin
            vpipe_d[0] = in_valid;
            for (int unsigned i = 1; i < LAT; i++) vpipe_d[i] = vpipe_q[i-1];
            if (push) begin
                if (count_q != '1) count_d = count_q + 1'b1;
                if (is_nan(dut_z)) nan_d = 1'b1;
            end else if (cap) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            nan_q   <= 1'b0;
        end else begin
            vpipe_q <= vpipe_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            nan_q   <= nan_d;
        end
    end

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .din   (dut_z),
        .pop   (pop),
        .dout  (out_data),
        .empty (empty),
        .full  (full)
    );

    assign count    = count_q;
    assign overflow = ovf_q;
    assign nan_seen = nan_q;

endmodule

// File: tb/tb_fp_result_collector.sv
// Randomized and directed bench for fp_result_collector against a
// queue-based model of capture timing, buffering and flags.
module tb_fp_result_collector;

    localparam int LAT   = fp_pkg::FPMUL_LAT;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst, in_valid, flush, out_ready;
    logic [31:0]      dut_z, out_data;
    logic             out_valid, overflow, nan_seen;
    logic [CNT_W-1:0] count;

    always #5 clk = ~clk;

    fp_result_collector #(
        .N     (32),
        .LAT   (LAT),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .dut_z     (dut_z),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .nan_seen  (nan_seen)
    );

    int checks = 0;
    int passes = 0;

    // Model: issue history by cycle, buffered results as a queue.
    bit          hist [int];
    logic [31:0] mq [$];
    int          m_cnt;
    bit          m_ovf, m_nan;
    int          t = 0;

    function automatic bit ref_nan(input logic [31:0] w);
        return (w[30:23] == 8'd255) && (w[22:0] != 23'd0);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
    endtask

    task automatic model_step();
        bit cap, pop, full;
        if (rst) begin
            hist.delete();
            mq.delete();
            m_cnt = 0;
            m_ovf = 0;
            m_nan = 0;
        end else if (flush) begin
            for (int k = t - LAT; k <= t; k++)
                if (hist.exists(k)) hist.delete(k);
            mq.delete();
            m_ovf = 0;
            m_nan = 0;
        end else begin
            cap  = hist.exists(t - LAT) && hist[t - LAT];
            hist[t] = in_valid;
            pop  = (mq.size() > 0) && out_ready;
            full = (mq.size() == DEPTH);
            if (pop) void'(mq.pop_front());
            if (cap) begin
                if (!full || pop) begin
                    mq.push_back(dut_z);
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                    if (ref_nan(dut_z)) m_nan = 1;
                end else begin
                    m_ovf = 1;
                end
            end
        end
        t++;
    endtask

    task automatic compare();
        chk("out_valid", out_valid, mq.size() > 0);
        chk("out_data", out_data, (mq.size() > 0) ? mq[0] : 32'd0);
        chk("count", count, m_cnt);
        chk("overflow", overflow, m_ovf);
        chk("nan_seen", nan_seen, m_nan);
    endtask

    // Called at a falling edge: drive one cycle, advance model, check after the edge.
    task automatic cyc(input bit iv, input logic [31:0] z, input bit fl, input bit rdy);
        in_valid  = iv;
        dut_z     = z;
        flush     = fl;
        out_ready = rdy;
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, $urandom, 0, rdy);
    endtask

    task automatic do_reset();
        rst = 1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst = 0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w[30:23] = 8'hFF;
            1: w = {w[31], 8'hFF, 23'd0};
            default: ;
        endcase
        return w;
    endfunction

    localparam logic [31:0] BASE  = 32'h3F80_0000;
    localparam logic [31:0] BASE2 = 32'h4100_0000;

    initial begin
        rst = 1; in_valid = 0; flush = 0; out_ready = 0; dut_z = '0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst count", count, 0);
        chk("rst overflow", overflow, 0);
        chk("rst nan_seen", nan_seen, 0);
        rst = 0;

        // Single sample
        idle(5, 1);
        cyc(1, $urandom, 0, 1);
        idle(LAT - 1, 1);
        chk("single early", out_valid, 0);
        cyc(0, 32'h4080_0000, 0, 1);
        chk("single valid", out_valid, 1);
        chk("single data", out_data, 32'h4080_0000);
        chk("single count", count, 1);
        cyc(0, 0, 0, 1);
        chk("single gone", out_valid, 0);

        // Burst overflow, reader stalled
        do_reset();
        for (int k = 0; k < 9 + LAT; k++) cyc(k < 9, BASE + k, 0, 0);
        chk("burst count", count, 8);
        chk("burst overflow", overflow, 1);
        chk("burst valid", out_valid, 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("burst drain", out_data, BASE + LAT + i);
            cyc(0, 0, 0, 1);
        end
        chk("burst empty", out_valid, 0);

        // Full with simultaneous pop
        do_reset();
        for (int k = 0; k < 9 + LAT; k++) cyc(k < 9, BASE2 + k, 0, k == 8 + LAT);
        chk("fullpop overflow", overflow, 0);
        chk("fullpop count", count, 9);
        chk("fullpop valid", out_valid, 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("fullpop drain", out_data, BASE2 + LAT + 1 + i);
            cyc(0, 0, 0, 1);
        end
        chk("fullpop empty", out_valid, 0);

        // NaN detection
        do_reset();
        cyc(1, 0, 0, 0); idle(LAT - 1, 0); cyc(0, 32'h7F80_0000, 0, 0);
        chk("inf no nan", nan_seen, 0);
        cyc(1, 0, 0, 0); idle(LAT - 1, 0); cyc(0, 32'h7FC0_0000, 0, 0);
        chk("nan set", nan_seen, 1);
        cyc(1, 0, 0, 0); idle(LAT - 1, 0); cyc(0, 32'h3F80_0000, 0, 0);
        chk("nan sticky", nan_seen, 1);
        cyc(0, 0, 1, 0);
        chk("nan flushed", nan_seen, 0);
        chk("nan flush count", count, 3);

        // Flush with buffered and in-flight samples
        do_reset();
        for (int k = 0; k < 8; k++) cyc(k < 3 || k == 5 || k == 6, $urandom, k == 7, 0);
        chk("flush valid", out_valid, 0);
        chk("flush count", count, 3);
        chk("flush overflow", overflow, 0);
        idle(LAT + 2, 1);
        chk("flush inflight", out_valid, 0);
        chk("flush count kept", count, 3);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 199) == 0,
                $urandom_range(0, 2) != 0);

        // Asynchronous reset mid-burst
        for (int k = 0; k < 12; k++) cyc(1, rand_word(), 0, 0);
        rst = 1;
        #1;
        chk("async rst valid", out_valid, 0);
        chk("async rst data", out_data, 0);
        chk("async rst count", count, 0);
        chk("async rst overflow", overflow, 0);
        chk("async rst nan", nan_seen, 0);
        cyc(1, 0, 0, 1);
        rst = 0;
        idle(LAT + 3, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fp_result_collector.md
Name: fp_result_collector

Overview:
- Receive-side counterpart of the stimulus generator: collects the results the pipelined FP multiplier produces for each issued operand.
- Tracks the operand-valid strobe through a LAT-deep shift register so it lines up with FP_Z, and captures each valid result into a DEPTH-entry FIFO.
- A downstream reader drains the FIFO with a ready/valid handshake. It sits between FPmul's FP_Z and the data sink / file writer.
- Also keeps a sample count and sticky overflow and NaN flags for the bench.

Parameters:
- N, 32, data width (IEEE-754 single precision; only N=32 supported)
- LAT, 4, FPmul latency in clock cycles from operand presentation to FP_Z; legal range 1..16
- DEPTH, 8, FIFO entries; power of 2, at least 2
- CNT_W, 16, width of the sample counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  high in the cycle a valid operand pair is presented to FPmul
- dut_z  in  N  FPmul FP_Z
- flush  in  1  synchronous clear
- out_data  out  N  FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  reader accepts head
- count  out  CNT_W  accepted results, saturating
- overflow  out  1  sticky: a result was dropped because the FIFO was full
- nan_seen  out  1  sticky: an accepted result was NaN

Behaviour:
- Reset (async, rst=1): vpipe, FIFO pointers, count, overflow and nan_seen all go to 0. out_valid=0 and out_data=0. The FIFO storage array is not reset.
- Valid pipe:
  - vpipe[0] <= in_valid; vpipe[i] <= vpipe[i-1].
  - cap = vpipe[LAT-1].
  - An operand presented in cycle c gives cap=1 in cycle c+LAT. dut_z is sampled at the edge that ends that cycle.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty = (wp==rp). full = (addr equal && wrap bits differ).
  - pop = out_valid && out_ready.
  - push = cap && (!full || pop). When full and pop happen in the same cycle, the push is accepted; no overflow.
  - cap && full && !pop: result dropped, overflow <= 1, count unchanged.
  - Pointers wrap naturally from DEPTH-1 to 0.
- Output: show-ahead. out_data = mem[rp addr] and out_valid = !empty. The first result appears in cycle c+LAT+1.
  - out_data is held stable while out_valid && !out_ready.
  - out_data = 0 when empty.
- Push and pop on an empty FIFO in the same cycle cannot occur, because out_valid=0.
- count increments on each push and saturates at 2^CNT_W-1.
- nan_seen <= 1 on a push with dut_z[30:23]==8'hFF && dut_z[22:0]!=0. Infinities do not set it.
- flush=1 (synchronous):
  - Clears vpipe, the pointers, overflow and nan_seen.
  - count is kept.
  - In-flight results are discarded; any push or pop in the same cycle is ignored.
- rst takes priority over everything. Asserting it mid-burst discards all in-flight and buffered data at once.
- No combinational path from out_ready to out_valid or out_data.

Decomposition:
- Shared package fp_pkg:
  - EXP_W=8, MANT_W=23, EXP_ALL_ONES=8'hFF
  - function is_nan(word)
  - FPMUL_LAT constant, used by both bench and RTL as the default for LAT
- Natural sub-module: sync_fifo (parameters N, DEPTH; ports clk, rst, clr, push, din, pop, dout, empty, full).
- The valid pipe, counter and flags stay in the top module.

Test Plan:
- Reset with rst=1 for 2 cycles, then release:
  - out_valid=0, out_data=0, count=0, overflow=0, nan_seen=0.
  - Pulsing rst mid-burst returns all outputs to 0 within the same cycle, without waiting for an edge.
- Single sample, LAT=4, out_ready=1:
  - Stimulus: in_valid=1 in cycle 10; dut_z=32'h40800000 during cycle 14.
  - out_valid=1 with out_data=32'h40800000 in cycle 15 only; count=1.
- Burst overflow, DEPTH=8, out_ready=0:
  - Stimulus: 9 consecutive valid samples.
  - After the 8th capture, out_valid=1 and the FIFO is full. The 9th is dropped: overflow=1, count=8.
  - Draining then yields the 8 values in order, and the 9th is never output.
- Full with simultaneous pop:
  - Stimulus: FIFO holds 8 entries, out_ready=1 in the cycle a 9th result is captured.
  - overflow stays 0, count=9, the FIFO stays full, and read order is preserved across the pointer wrap.
- NaN detection:
  - Capturing 32'h7F800000 leaves nan_seen=0.
  - Capturing 32'h7FC00000 sets nan_seen=1, and it stays 1 through later normal results until flush.
- Flush:
  - Stimulus: 3 buffered entries plus 2 samples in vpipe, flush=1 for one cycle.
  - Next cycle out_valid=0. The 2 in-flight results are never captured. count is unchanged and overflow=0.
